// File: rtl/rb_stream_controller_pkg.sv
// Shared constants, FSM encoding and slot-rotation helper for the row-buffer stream controller.
package rb_stream_controller_pkg;

    localparam int DEF_PIXEL_WIDTH  = 8;
    localparam int DEF_RBS          = 4;
    localparam int DEF_IMG_WIDTH    = 640;
    localparam int DEF_BRAM_DEPTH   = DEF_IMG_WIDTH * DEF_RBS;
    localparam int DEF_W_ADDR_WIDTH = $clog2(DEF_BRAM_DEPTH);
    localparam int DEF_R_ADDR_WIDTH = $clog2(DEF_IMG_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Buffer feeding window slot k when the current row lives in buffer sel.
    function automatic int rot_slot(input int sel, input int k, input int rbs);
        return (sel + 1 + k) % rbs;
    endfunction

endpackage

// File: rtl/rb_stream_controller_if.sv
// Pixel-in / window-out handshakes plus both BRAM ports of the row-buffer stream controller.
interface rb_stream_controller_if
    import rb_stream_controller_pkg::*;
#(
    parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter int RBS          = DEF_RBS,
    parameter int W_ADDR_WIDTH = DEF_W_ADDR_WIDTH,
    parameter int R_ADDR_WIDTH = DEF_R_ADDR_WIDTH
) ();

    logic                       IN_VALID;
    logic                       IN_READY;
    logic [PIXEL_WIDTH-1:0]     IN_PIXEL;
    logic                       IN_SOF;
    logic                       EN_A;
    logic [W_ADDR_WIDTH-1:0]    ADDR_A;
    logic [PIXEL_WIDTH-1:0]     DIN_A;
    logic                       EN_B;
    logic [R_ADDR_WIDTH-1:0]    ADDR_B;
    logic [RBS*PIXEL_WIDTH-1:0] DOUT_B;
    logic                       OUT_VALID;
    logic                       OUT_READY;
    logic [RBS*PIXEL_WIDTH-1:0] OUT_WIN;
    logic                       OUT_EOL;

    modport master (
        input  IN_VALID, IN_PIXEL, IN_SOF, DOUT_B, OUT_READY,
        output IN_READY, EN_A, ADDR_A, DIN_A, EN_B, ADDR_B, OUT_VALID, OUT_WIN, OUT_EOL
    );

    modport slave (
        output IN_VALID, IN_PIXEL, IN_SOF, DOUT_B, OUT_READY,
        input  IN_READY, EN_A, ADDR_A, DIN_A, EN_B, ADDR_B, OUT_VALID, OUT_WIN, OUT_EOL
    );

endinterface

// File: rtl/rb_stream_controller_window_rotate.sv
// Reorders the packed BRAM read word oldest-row-first and drops the live pixel into the top slot.
module rb_window_rotate
    import rb_stream_controller_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int RBS         = DEF_RBS,
    parameter int SEL_W       = 2
) (
    input  logic [RBS*PIXEL_WIDTH-1:0] i_dout_b,
    input  logic [SEL_W-1:0]           i_sel,
    input  logic [PIXEL_WIDTH-1:0]     i_pixel,
    output logic [RBS*PIXEL_WIDTH-1:0] o_win
);

    always_comb begin
        o_win = '0;
        for (int k = 0; k < RBS - 1; k++) begin
            o_win[k*PIXEL_WIDTH +: PIXEL_WIDTH] =
                i_dout_b[rot_slot(int'(i_sel), k, RBS)*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
        o_win[(RBS-1)*PIXEL_WIDTH +: PIXEL_WIDTH] = i_pixel;
    end

endmodule

// File: rtl/rb_stream_controller.sv
// Row-buffer BRAM initiator: writes each raster pixel and emits a registered vertical window of RBS rows.
module rb_stream_controller
    import rb_stream_controller_pkg::*;
#(
    parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter int RBS          = DEF_RBS,
    parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
    parameter int W_ADDR_WIDTH = DEF_W_ADDR_WIDTH,
    parameter int R_ADDR_WIDTH = DEF_R_ADDR_WIDTH
) (
    input  logic CLK,
    input  logic RST_N,
    rb_stream_controller_if.master bus
);

    localparam int SEL_W = (RBS > 1) ? $clog2(RBS) : 1;
    localparam int WIN_W = RBS * PIXEL_WIDTH;
    localparam logic [R_ADDR_WIDTH-1:0] COL_LAST = R_ADDR_WIDTH'(IMG_WIDTH - 1);
    localparam logic [SEL_W-1:0]        SEL_LAST = SEL_W'(RBS - 1);

    function automatic logic [SEL_W-1:0] sel_wrap_inc(input logic [SEL_W-1:0] v);
        return (v == SEL_LAST) ? '0 : v + SEL_W'(1);
    endfunction

    function automatic logic [SEL_W-1:0] rows_sat_inc(input logic [SEL_W-1:0] v);
        return (v == SEL_LAST) ? SEL_LAST : v + SEL_W'(1);
    endfunction

    state_t                  r_state, w_state_nxt;
    logic [R_ADDR_WIDTH-1:0] r_col, w_col_eff, w_col_nxt;
    logic [SEL_W-1:0]        r_sel, w_sel_eff, w_sel_nxt;
    logic [SEL_W-1:0]        r_rows, w_rows_eff, w_rows_nxt;
    logic                    w_in_ready, w_acc, w_proc;
    logic [WIN_W-1:0]        w_win;

    logic                    r_vld_p1, r_eol_p1;
    logic [WIN_W-1:0]        r_win_p1;
    logic                    r_en_a_p1;
    logic [W_ADDR_WIDTH-1:0] r_addr_a_p1;
    logic [PIXEL_WIDTH-1:0]  r_din_a_p1;

    // IN_SOF forces the accepted pixel to row 0 / col 0 regardless of where the counters stand.
    assign w_in_ready = !r_vld_p1 || bus.OUT_READY;
    assign w_acc      = bus.IN_VALID && w_in_ready;
    assign w_proc     = w_acc && ((r_state != ST_IDLE) || bus.IN_SOF);
    assign w_col_eff  = bus.IN_SOF ? '0 : r_col;
    assign w_sel_eff  = bus.IN_SOF ? '0 : r_sel;
    assign w_rows_eff = bus.IN_SOF ? '0 : r_rows;

    rb_window_rotate #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .RBS         (RBS),
        .SEL_W       (SEL_W)
    ) u_rotate (
        .i_dout_b (bus.DOUT_B),
        .i_sel    (w_sel_eff),
        .i_pixel  (bus.IN_PIXEL),
        .o_win    (w_win)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_sel_nxt   = r_sel;
        w_rows_nxt  = r_rows;
        if (w_proc) begin
            if (bus.IN_SOF)
                w_state_nxt = ST_FILL;
            else if (r_state == ST_FILL && r_rows == SEL_LAST && r_col == '0)
                w_state_nxt = ST_STREAM;
            if (w_col_eff == COL_LAST) begin
                w_col_nxt  = '0;
                w_sel_nxt  = sel_wrap_inc(w_sel_eff);
                w_rows_nxt = rows_sat_inc(w_rows_eff);
            end else begin
                w_col_nxt  = w_col_eff + R_ADDR_WIDTH'(1);
                w_sel_nxt  = w_sel_eff;
                w_rows_nxt = w_rows_eff;
            end
        end
    end

    // Stage p0 -> p1: window register and BRAM write command, both launched by the accepting edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_col       <= '0;
            r_sel       <= '0;
            r_rows      <= '0;
            r_vld_p1    <= 1'b0;
            r_win_p1    <= '0;
            r_eol_p1    <= 1'b0;
            r_en_a_p1   <= 1'b0;
            r_addr_a_p1 <= '0;
            r_din_a_p1  <= '0;
        end else begin
            r_col     <= w_col_nxt;
            r_sel     <= w_sel_nxt;
            r_rows    <= w_rows_nxt;
            r_en_a_p1 <= w_proc;
            if (w_proc) begin
                r_addr_a_p1 <= W_ADDR_WIDTH'(w_col_eff) * W_ADDR_WIDTH'(RBS)
                             + W_ADDR_WIDTH'(w_sel_eff);
                r_din_a_p1  <= bus.IN_PIXEL;
                r_vld_p1    <= (w_state_nxt == ST_STREAM);
                r_win_p1    <= w_win;
                r_eol_p1    <= (w_col_eff == COL_LAST);
            end else if (bus.OUT_READY) begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.IN_READY  = w_in_ready;
    assign bus.EN_B      = w_proc;
    assign bus.ADDR_B    = w_col_eff;
    assign bus.EN_A      = r_en_a_p1;
    assign bus.ADDR_A    = r_addr_a_p1;
    assign bus.DIN_A     = r_din_a_p1;
    assign bus.OUT_VALID = r_vld_p1;
    assign bus.OUT_WIN   = r_win_p1;
    assign bus.OUT_EOL   = r_eol_p1;

endmodule

// File: tb/tb_rb_stream_controller.sv
// Directed bench for rb_stream_controller with RBS=4, IMG_WIDTH=4 and a behavioural row-buffer BRAM.
module tb_rb_stream_controller;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic       obs_en_b;
    logic       obs_in_ready;
    logic [1:0] obs_addr_b;
    logic [7:0] pix;

    always #5 CLK = ~CLK;

    rb_stream_controller_if #(
        .PIXEL_WIDTH(8), .RBS(4), .W_ADDR_WIDTH(4), .R_ADDR_WIDTH(2)
    ) bus ();

    rb_stream_controller #(
        .PIXEL_WIDTH(8), .RBS(4), .IMG_WIDTH(4), .W_ADDR_WIDTH(4), .R_ADDR_WIDTH(2)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // Row-buffer memory: single-pixel write port, combinational packed read of one column.
    logic [7:0] mem [16] = '{default: 8'h00};

    always @(posedge CLK) begin
        if (bus.EN_A) mem[bus.ADDR_A] <= bus.DIN_A;
    end

    always_comb begin
        bus.DOUT_B = '0;
        for (int j = 0; j < 4; j++) bus.DOUT_B[j*8 +: 8] = mem[{bus.ADDR_B, 2'(j)}];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, capture the combinational outputs, then step past the edge.
    task automatic cyc(input logic v, input logic [7:0] p, input logic sof, input logic rdy);
        bus.IN_VALID  = v;
        bus.IN_PIXEL  = p;
        bus.IN_SOF    = sof;
        bus.OUT_READY = rdy;
        #1;
        obs_en_b     = bus.EN_B;
        obs_in_ready = bus.IN_READY;
        obs_addr_b   = bus.ADDR_B;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bus.IN_VALID  = 1'b0;
        bus.IN_PIXEL  = 8'h00;
        bus.IN_SOF    = 1'b0;
        bus.OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        check("rst_out_win",   bus.OUT_WIN,        32'h0);
        check("rst_out_eol",   32'(bus.OUT_EOL),   32'd0);
        check("rst_en_a",      32'(bus.EN_A),      32'd0);
        check("rst_addr_a",    32'(bus.ADDR_A),    32'd0);
        check("rst_din_a",     32'(bus.DIN_A),     32'd0);
        check("rst_en_b",      32'(bus.EN_B),      32'd0);
        RST_N = 1'b1;

        // Pixels before any start-of-frame are swallowed.
        cyc(1'b1, 8'h55, 1'b0, 1'b1);
        check("idle_en_b",     32'(obs_en_b),     32'd0);
        check("idle_in_ready", 32'(obs_in_ready), 32'd1);
        cyc(1'b1, 8'h56, 1'b0, 1'b1);
        check("idle_en_a",     32'(bus.EN_A),      32'd0);
        check("idle_out_valid", 32'(bus.OUT_VALID), 32'd0);

        // Fill rows 0..2.
        for (int i = 0; i < 12; i++) begin
            pix = 8'((i / 4) * 16 + (i % 4));
            cyc(1'b1, pix, (i == 0), 1'b1);
            if (pix == 8'h21) begin
                check("rd_en_b_21",   32'(obs_en_b),   32'd1);
                check("rd_addr_b_21", 32'(obs_addr_b), 32'd1);
                check("wr_en_a_21",   32'(bus.EN_A),   32'd1);
                check("wr_addr_a_21", 32'(bus.ADDR_A), 32'd6);
                check("wr_din_a_21",  32'(bus.DIN_A),  32'h21);
                cyc(1'b0, 8'h00, 1'b0, 1'b1);
                check("wr_pulse_end", 32'(bus.EN_A),   32'd0);
                check("rd_idle_en_b", 32'(obs_en_b),   32'd0);
            end
            check("fill_out_valid", 32'(bus.OUT_VALID), 32'd0);
        end

        // Row 3 starts streaming windows.
        cyc(1'b1, 8'h30, 1'b0, 1'b1);
        check("w30_valid", 32'(bus.OUT_VALID), 32'd1);
        check("w30_win",   bus.OUT_WIN,        32'h30201000);
        check("w30_eol",   32'(bus.OUT_EOL),   32'd0);
        cyc(1'b1, 8'h31, 1'b0, 1'b1);
        check("w31_win",   bus.OUT_WIN,        32'h31211101);
        cyc(1'b1, 8'h32, 1'b0, 1'b1);
        check("w32_win",   bus.OUT_WIN,        32'h32221202);
        check("w32_eol",   32'(bus.OUT_EOL),   32'd0);
        cyc(1'b1, 8'h33, 1'b0, 1'b1);
        check("w33_win",   bus.OUT_WIN,        32'h33231303);
        check("w33_eol",   32'(bus.OUT_EOL),   32'd1);
        cyc(1'b1, 8'h40, 1'b0, 1'b1);
        check("w40_win",   bus.OUT_WIN,        32'h40302010);
        check("w40_eol",   32'(bus.OUT_EOL),   32'd0);
        check("w40_en_a",  32'(bus.EN_A),      32'd1);
        check("w40_addr_a", 32'(bus.ADDR_A),   32'd0);

        // Downstream stall: only the in-flight write may still appear.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h41, 1'b0, 1'b0);
            check("stall_in_ready", 32'(obs_in_ready),  32'd0);
            check("stall_valid",    32'(bus.OUT_VALID), 32'd1);
            check("stall_win",      bus.OUT_WIN,        32'h40302010);
            check("stall_en_a",     32'(bus.EN_A),      32'd0);
        end
        cyc(1'b1, 8'h41, 1'b0, 1'b1);
        check("w41_win",    bus.OUT_WIN,      32'h41312111);
        check("w41_en_a",   32'(bus.EN_A),    32'd1);
        check("w41_addr_a", 32'(bus.ADDR_A),  32'd4);
        check("w41_din_a",  32'(bus.DIN_A),   32'h41);
        cyc(1'b1, 8'h42, 1'b0, 1'b1);
        check("w42_win",    bus.OUT_WIN,      32'h42322212);
        cyc(1'b1, 8'h43, 1'b0, 1'b1);
        check("w43_win",    bus.OUT_WIN,      32'h43332313);
        check("w43_eol",    32'(bus.OUT_EOL), 32'd1);
        cyc(1'b1, 8'h50, 1'b0, 1'b1);
        check("w50_win",    bus.OUT_WIN,      32'h50403020);

        // Mid-line start-of-frame restarts filling from buffer 0.
        for (int i = 0; i < 12; i++) begin
            pix = 8'(8'h80 + (i / 4) * 16 + (i % 4));
            cyc(1'b1, pix, (i == 0), 1'b1);
            if (i == 0) begin
                check("sof_addr_b", 32'(obs_addr_b), 32'd0);
                check("sof_addr_a", 32'(bus.ADDR_A), 32'd0);
            end
            check("refill_out_valid", 32'(bus.OUT_VALID), 32'd0);
        end
        cyc(1'b1, 8'hB0, 1'b0, 1'b1);
        check("wB0_valid", 32'(bus.OUT_VALID), 32'd1);
        check("wB0_win",   bus.OUT_WIN,        32'hB0A09080);
        cyc(1'b1, 8'hB1, 1'b0, 1'b1);
        check("wB1_win",   bus.OUT_WIN,        32'hB1A19181);

        // Asynchronous reset between clock edges.
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        check("arst_out_win",   bus.OUT_WIN,        32'h0);
        check("arst_out_eol",   32'(bus.OUT_EOL),   32'd0);
        check("arst_en_a",      32'(bus.EN_A),      32'd0);
        check("arst_addr_a",    32'(bus.ADDR_A),    32'd0);
        check("arst_din_a",     32'(bus.DIN_A),     32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        cyc(1'b1, 8'hB2, 1'b0, 1'b1);
        check("post_rst_en_b",  32'(obs_en_b),      32'd0);
        check("post_rst_en_a",  32'(bus.EN_A),      32'd0);
        check("post_rst_valid", 32'(bus.OUT_VALID), 32'd0);
        cyc(1'b1, 8'h00, 1'b1, 1'b1);
        check("post_sof_en_b",  32'(obs_en_b),      32'd1);
        check("post_sof_en_a",  32'(bus.EN_A),      32'd1);
        check("post_sof_valid", 32'(bus.OUT_VALID), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
